avalon_reg_bridge: RTL and testbench

- Avalon-MM slave front end sitting directly upstream of the GPIO address decoder/register block.
- Converts HPS lightweight-bridge read/write transactions into single-cycle read_reg/write_reg strobes, with stable busaddress/busdata_in.
- Holds avs_waitrequest until the decoder's fixed internal pipeline latency has elapsed, then captures busdata_to_cpu as readdata.
- Single clock domain (reg_clk).

---
 rtl/gpio_bus_pkg.sv | 27 ++
 rtl/avalon_reg_bridge.sv | 131 +++++++++++++
 tb/tb_avalon_reg_bridge.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/gpio_bus_pkg.sv
// Shared GPIO register-bus definitions: bridge FSM states, default timing,
// and the decoder's register map (byte addresses).
package gpio_bus_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_STROBE = 3'd1,
    WR_HOLD   = 3'd2,
    RD_STROBE = 3'd3,
    RD_WAIT   = 3'd4,
    DONE      = 3'd5
  } bridge_state_t;

  localparam int DEF_READ_LATENCY = 5;
  localparam int DEF_WRITE_HOLD   = 4;

  // Wide enough for any latency/hold setting up to 15.
  localparam int CNT_WIDTH = $clog2(16);

  localparam logic [15:0] ADDR_ADC     = 16'h0300;
  localparam logic [15:0] ADDR_TOUCH   = 16'h0308;
  localparam logic [15:0] ADDR_IO      = 16'h1000;
  localparam logic [15:0] ADDR_DDR     = 16'h1100;
  localparam logic [15:0] ADDR_PORTNUM = 16'h1120;
  localparam logic [15:0] ADDR_OD      = 16'h1300;

endpackage

// File: rtl/avalon_reg_bridge.sv
// Avalon-MM slave that turns lightweight-bridge transfers into one-cycle
// read_reg/write_reg strobes and stalls until the decoder pipeline settles.
module avalon_reg_bridge
  import gpio_bus_pkg::*;
#(
  parameter int AddrWidth   = 16,
  parameter int BusWidth    = 32,
  parameter int ReadLatency = DEF_READ_LATENCY,
  parameter int WriteHold   = DEF_WRITE_HOLD
) (
  input  logic                 reg_clk,
  input  logic                 reset_in,
  input  logic [AddrWidth-3:0] avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [BusWidth-1:0]  avs_writedata,
  output logic [BusWidth-1:0]  avs_readdata,
  output logic                 avs_waitrequest,
  output logic                 chip_sel,
  output logic                 read_reg,
  output logic                 write_reg,
  output logic [AddrWidth-3:0] busaddress,
  output logic [BusWidth-1:0]  busdata_in,
  input  logic [BusWidth-1:0]  busdata_to_cpu,
  output logic                 protocol_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] RD_LOAD  = CNT_WIDTH'(ReadLatency - 1);
  localparam logic [CNT_WIDTH-1:0] WR_LOAD  = CNT_WIDTH'(WriteHold - 1);

  bridge_state_t          state_r;
  bridge_state_t          state_next_s;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic                   accept_wr_s;
  logic                   accept_rd_s;
  logic                   capture_s;

  // Next-state decode; a write wins when both requests arrive together.
  always_comb begin
    state_next_s = state_r;
    accept_wr_s  = 1'b0;
    accept_rd_s  = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (avs_write) begin
          state_next_s = WR_STROBE;
          accept_wr_s  = 1'b1;
        end else if (avs_read) begin
          state_next_s = RD_STROBE;
          accept_rd_s  = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      WR_STROBE: state_next_s = WR_HOLD;
      WR_HOLD: begin
        if (cnt_r == CNT_ZERO) begin
          state_next_s = DONE;
        end else begin
          state_next_s = WR_HOLD;
        end
      end
      RD_STROBE: state_next_s = RD_WAIT;
      RD_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_next_s = DONE;
          capture_s    = 1'b1;
        end else begin
          state_next_s = RD_WAIT;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register and wait/hold down-counter.
  always_ff @(posedge reg_clk) begin
    if (reset_in) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        WR_STROBE: cnt_r <= WR_LOAD;
        RD_STROBE: cnt_r <= RD_LOAD;
        WR_HOLD, RD_WAIT: begin
          if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_r.
  always_ff @(posedge reg_clk) begin
    if (reset_in) begin
      avs_waitrequest <= 1'b1;
      chip_sel        <= 1'b0;
      read_reg        <= 1'b0;
      write_reg       <= 1'b0;
      protocol_err    <= 1'b0;
      busaddress      <= {(AddrWidth-2){1'b0}};
      busdata_in      <= {BusWidth{1'b0}};
      avs_readdata    <= {BusWidth{1'b0}};
    end else begin
      avs_waitrequest <= (state_next_s != DONE);
      chip_sel        <= (state_next_s inside {WR_STROBE, WR_HOLD, RD_STROBE, RD_WAIT});
      read_reg        <= accept_rd_s;
      write_reg       <= accept_wr_s;
      protocol_err    <= accept_wr_s & avs_read;
      if (accept_wr_s | accept_rd_s) begin
        busaddress <= avs_address;
      end
      if (accept_wr_s) begin
        busdata_in <= avs_writedata;
      end
      if (capture_s) begin
        avs_readdata <= busdata_to_cpu;
      end
    end
  end

endmodule

// File: tb/tb_avalon_reg_bridge.sv
// Directed bench for avalon_reg_bridge: default-timing instance plus a
// ReadLatency=1/WriteHold=1 instance, each with a simple decoder read model.
module tb_avalon_reg_bridge;

  logic        reg_clk = 1'b0;
  logic        reset_in = 1'b1;

  logic [13:0] avs_address = 14'h0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'h0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest, chip_sel, read_reg, write_reg, protocol_err;
  logic [13:0] busaddress;
  logic [31:0] busdata_in, busdata_to_cpu;

  logic [13:0] s_address = 14'h0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = 32'h0;
  logic [31:0] s_readdata;
  logic        s_waitrequest, s_chip_sel, s_read_reg, s_write_reg, s_protocol_err;
  logic [13:0] s_busaddress;
  logic [31:0] s_busdata_in, s_busdata_to_cpu;

  int total = 0;
  int bad = 0;

  always #5 reg_clk = ~reg_clk;

  avalon_reg_bridge dut (
    .reg_clk(reg_clk), .reset_in(reset_in),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest), .chip_sel(chip_sel),
    .read_reg(read_reg), .write_reg(write_reg), .busaddress(busaddress),
    .busdata_in(busdata_in), .busdata_to_cpu(busdata_to_cpu),
    .protocol_err(protocol_err)
  );

  avalon_reg_bridge #(.ReadLatency(1), .WriteHold(1)) dut_fast (
    .reg_clk(reg_clk), .reset_in(reset_in),
    .avs_address(s_address), .avs_read(s_read), .avs_write(s_write),
    .avs_writedata(s_writedata), .avs_readdata(s_readdata),
    .avs_waitrequest(s_waitrequest), .chip_sel(s_chip_sel),
    .read_reg(s_read_reg), .write_reg(s_write_reg), .busaddress(s_busaddress),
    .busdata_in(s_busdata_in), .busdata_to_cpu(s_busdata_to_cpu),
    .protocol_err(s_protocol_err)
  );

  // Decoder models: data valid only once the read latency has elapsed after read_reg.
  logic [31:0] dec_val = 32'h0;
  logic [31:0] s_dec_val = 32'h0;
  logic [3:0]  age = 4'd0;
  logic [3:0]  s_age = 4'd0;

  always @(posedge reg_clk) begin
    if (read_reg) age <= 4'd1;
    else if (age != 4'd0 && age != 4'd15) age <= age + 4'd1;
    if (s_read_reg) s_age <= 4'd1;
    else if (s_age != 4'd0 && s_age != 4'd15) s_age <= s_age + 4'd1;
  end

  assign busdata_to_cpu   = (age >= 4'd5)   ? dec_val   : 32'hDEADBEEF;
  assign s_busdata_to_cpu = (s_age >= 4'd1) ? s_dec_val : 32'hDEADBEEF;

  task automatic test_reset();
    reset_in = 1'b1;
    repeat (3) @(posedge reg_clk);
    #1;
    total++; if (avs_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wait got=%b exp=1", avs_waitrequest); end
    total++; if ({read_reg, write_reg, chip_sel, protocol_err} !== 4'b0000) begin bad++; $display("FAIL rst_strobes got=%b exp=0000", {read_reg, write_reg, chip_sel, protocol_err}); end
    total++; if (busaddress !== 14'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", busaddress); end
    total++; if (busdata_in !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", busdata_in); end
    total++; if (avs_readdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", avs_readdata); end
    total++; if ({s_waitrequest, s_chip_sel, s_readdata} !== {1'b1, 1'b0, 32'h0}) begin bad++; $display("FAIL rst_fast got=%b/%b/%h exp=1/0/0", s_waitrequest, s_chip_sel, s_readdata); end
    reset_in = 1'b0;
    @(posedge reg_clk); #1;
    total++; if (avs_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_idle_wait got=%b exp=1", avs_waitrequest); end
  endtask

  task automatic test_write();
    avs_address = 14'h440; avs_writedata = 32'h00FFFFFF; avs_write = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge reg_clk); #1;
      total++; if (write_reg !== (k == 1)) begin bad++; $display("FAIL wr_strobe cyc=%0d got=%b exp=%b", k, write_reg, (k == 1)); end
      total++; if (read_reg !== 1'b0) begin bad++; $display("FAIL wr_no_rd cyc=%0d got=%b exp=0", k, read_reg); end
      total++; if (avs_waitrequest !== (k != 6)) begin bad++; $display("FAIL wr_wait cyc=%0d got=%b exp=%b", k, avs_waitrequest, (k != 6)); end
      total++; if (chip_sel !== (k <= 5)) begin bad++; $display("FAIL wr_cs cyc=%0d got=%b exp=%b", k, chip_sel, (k <= 5)); end
      total++; if (busaddress !== 14'h440) begin bad++; $display("FAIL wr_addr cyc=%0d got=%h exp=440", k, busaddress); end
      total++; if (busdata_in !== 32'h00FFFFFF) begin bad++; $display("FAIL wr_data cyc=%0d got=%h exp=00ffffff", k, busdata_in); end
      if (k == 1) begin avs_writedata = 32'h12345678; avs_address = 14'h001; end
      if (k == 6) avs_write = 1'b0;
    end
    total++; if (avs_readdata !== 32'h0) begin bad++; $display("FAIL wr_rdata_hold got=%h exp=0", avs_readdata); end
  endtask

  task automatic test_read();
    dec_val = 32'h00A5A5A5; avs_address = 14'h400; avs_read = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge reg_clk); #1;
      total++; if (read_reg !== (k == 1)) begin bad++; $display("FAIL rd_strobe cyc=%0d got=%b exp=%b", k, read_reg, (k == 1)); end
      total++; if (avs_waitrequest !== (k != 7)) begin bad++; $display("FAIL rd_wait cyc=%0d got=%b exp=%b", k, avs_waitrequest, (k != 7)); end
      total++; if (chip_sel !== (k <= 6)) begin bad++; $display("FAIL rd_cs cyc=%0d got=%b exp=%b", k, chip_sel, (k <= 6)); end
      total++; if (avs_readdata !== ((k >= 7) ? 32'h00A5A5A5 : 32'h0)) begin bad++; $display("FAIL rd_data cyc=%0d got=%h", k, avs_readdata); end
      total++; if (busaddress !== 14'h400) begin bad++; $display("FAIL rd_addr cyc=%0d got=%h exp=400", k, busaddress); end
      if (k == 7) avs_read = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int wr_pulses = 0;
    int rd_pulses = 0;
    dec_val = 32'h00000077;
    avs_address = 14'h4C0; avs_writedata = 32'hCAFEF00D; avs_write = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge reg_clk); #1;
      if (write_reg === 1'b1) wr_pulses++;
      if (read_reg === 1'b1) rd_pulses++;
      total++; if (avs_waitrequest !== !(k == 6 || k == 14)) begin bad++; $display("FAIL b2b_wait cyc=%0d got=%b", k, avs_waitrequest); end
      total++; if (read_reg !== (k == 8)) begin bad++; $display("FAIL b2b_rd_strobe cyc=%0d got=%b exp=%b", k, read_reg, (k == 8)); end
      total++; if (busaddress !== ((k <= 7) ? 14'h4C0 : 14'h4C1)) begin bad++; $display("FAIL b2b_addr cyc=%0d got=%h", k, busaddress); end
      if (k == 13) begin
        total++; if (avs_readdata !== 32'h00A5A5A5) begin bad++; $display("FAIL b2b_early_data got=%h exp=00a5a5a5", avs_readdata); end
      end
      if (k == 14) begin
        total++; if (avs_readdata !== 32'h00000077) begin bad++; $display("FAIL b2b_rdata got=%h exp=00000077", avs_readdata); end
        avs_read = 1'b0;
      end
      if (k == 6) begin avs_write = 1'b0; avs_read = 1'b1; avs_address = 14'h4C1; end
    end
    total++; if (wr_pulses != 1) begin bad++; $display("FAIL b2b_wr_count got=%0d exp=1", wr_pulses); end
    total++; if (rd_pulses != 1) begin bad++; $display("FAIL b2b_rd_count got=%0d exp=1", rd_pulses); end
    total++; if (busdata_in !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_wdata_hold got=%h exp=cafef00d", busdata_in); end
  endtask

  task automatic test_protocol_err();
    avs_address = 14'h448; avs_writedata = 32'h00000005; avs_write = 1'b1; avs_read = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge reg_clk); #1;
      total++; if (protocol_err !== (k == 1)) begin bad++; $display("FAIL perr_pulse cyc=%0d got=%b exp=%b", k, protocol_err, (k == 1)); end
      total++; if (write_reg !== (k == 1)) begin bad++; $display("FAIL perr_wr cyc=%0d got=%b exp=%b", k, write_reg, (k == 1)); end
      total++; if (read_reg !== 1'b0) begin bad++; $display("FAIL perr_rd cyc=%0d got=%b exp=0", k, read_reg); end
      total++; if (avs_waitrequest !== (k != 6)) begin bad++; $display("FAIL perr_wait cyc=%0d got=%b exp=%b", k, avs_waitrequest, (k != 6)); end
      if (k == 6) begin avs_write = 1'b0; avs_read = 1'b0; end
    end
    total++; if (busdata_in !== 32'h00000005) begin bad++; $display("FAIL perr_wdata got=%h exp=5", busdata_in); end
    total++; if (avs_readdata !== 32'h00000077) begin bad++; $display("FAIL perr_rdata_hold got=%h exp=77", avs_readdata); end
  endtask

  task automatic test_reset_mid_read();
    dec_val = 32'h0BADF00D; avs_address = 14'h400; avs_read = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(posedge reg_clk); #1;
      total++; if (read_reg !== (k == 1)) begin bad++; $display("FAIL mrst_strobe cyc=%0d got=%b", k, read_reg); end
    end
    reset_in = 1'b1; avs_read = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge reg_clk); #1;
      total++; if ({avs_waitrequest, chip_sel, read_reg, write_reg} !== 4'b1000) begin bad++; $display("FAIL mrst_ctl cyc=%0d got=%b exp=1000", k, {avs_waitrequest, chip_sel, read_reg, write_reg}); end
      total++; if (busaddress !== 14'h0 || avs_readdata !== 32'h0) begin bad++; $display("FAIL mrst_regs cyc=%0d got=%h/%h exp=0/0", k, busaddress, avs_readdata); end
    end
    reset_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge reg_clk); #1;
      total++; if ({avs_waitrequest, chip_sel, avs_readdata} !== {1'b1, 1'b0, 32'h0}) begin bad++; $display("FAIL mrst_no_done cyc=%0d got=%b/%b/%h", k, avs_waitrequest, chip_sel, avs_readdata); end
    end
  endtask

  task automatic test_sweep();
    s_address = 14'h010; s_writedata = 32'h0000000A; s_write = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge reg_clk); #1;
      total++; if (s_write_reg !== (k == 1)) begin bad++; $display("FAIL sw_wr_strobe cyc=%0d got=%b", k, s_write_reg); end
      total++; if (s_waitrequest !== (k != 3)) begin bad++; $display("FAIL sw_wr_wait cyc=%0d got=%b exp=%b", k, s_waitrequest, (k != 3)); end
      total++; if (s_chip_sel !== (k <= 2)) begin bad++; $display("FAIL sw_wr_cs cyc=%0d got=%b exp=%b", k, s_chip_sel, (k <= 2)); end
      if (k == 3) s_write = 1'b0;
    end
    total++; if (s_busdata_in !== 32'h0000000A) begin bad++; $display("FAIL sw_wdata got=%h exp=a", s_busdata_in); end
    s_dec_val = 32'h00000011; s_address = 14'h011; s_read = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge reg_clk); #1;
      total++; if (s_read_reg !== (k == 1)) begin bad++; $display("FAIL sw_rd_strobe cyc=%0d got=%b", k, s_read_reg); end
      total++; if (s_waitrequest !== (k != 3)) begin bad++; $display("FAIL sw_rd_wait cyc=%0d got=%b exp=%b", k, s_waitrequest, (k != 3)); end
      total++; if (s_readdata !== ((k >= 3) ? 32'h00000011 : 32'h0)) begin bad++; $display("FAIL sw_rdata cyc=%0d got=%h", k, s_readdata); end
      if (k == 3) s_read = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_protocol_err();
    test_reset_mid_read();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
